// File: rtl/program_loader.sv
// Instruction-memory load port writer: takes a length-prefixed byte stream and writes
// little-endian words into imem, keeping the core held in reset until a complete program is loaded.
module program_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  start,
   input  logic [BYTE_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [ADDR_WIDTH-1:0] imem_wr_addr,
   output logic [DATA_WIDTH-1:0] imem_wr_data,
   output logic                  imem_wr_en,
   output logic                  core_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded
);

   // state  | meaning
   // IDLE   | after reset, waiting for start
   // LEN_LO | receiving length byte 0
   // LEN_HI | receiving length byte 1, checking range
   // DATA   | collecting the 4 bytes of the current word
   // WRITE  | one-cycle imem write strobe
   // DONE   | program loaded, core released
   // ERROR  | declared length too large, core held
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             len_q, len_d;
   logic [1:0]              byte_idx_q, byte_idx_d;
   logic [15:0]             word_idx_q, word_idx_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [15:0]             len_full;
   logic                    xfer;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign rx_ready     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
   assign busy         = rx_ready || (state_q == S_WRITE);
   assign imem_wr_en   = (state_q == S_WRITE);
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERROR);
   assign core_hold    = (state_q != S_DONE);
   assign imem_wr_addr = addr_q;
   assign imem_wr_data = data_q;
   assign words_loaded = word_idx_q;
   assign xfer         = rx_valid && rx_ready;
   assign len_full     = {rx_data, len_q[7:0]};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      word_d     = word_q;
      addr_d     = addr_q;
      data_d     = data_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d    = S_LEN_LO;
               len_d      = '0;
               byte_idx_d = '0;
               word_idx_d = '0;
               word_d     = '0;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = rx_data;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d = len_full;
               if (len_full == 16'd0)                  state_d = S_DONE;
               else if (len_full > 16'(MEM_DEPTH))     state_d = S_ERROR;
               else                                    state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d[int'(byte_idx_q)*BYTE_WIDTH +: BYTE_WIDTH] = rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               // Last byte goes straight into the output register so the write strobe sees a full word.
               if (byte_idx_q == 2'd3) begin
                  state_d = S_WRITE;
                  addr_d  = ADDR_WIDTH'({word_idx_q, 2'b00});
                  data_d  = {rx_data, word_q[DATA_WIDTH-BYTE_WIDTH-1:0]};
               end
            end
         end
         S_WRITE: begin
            word_idx_d = word_idx_q + 16'd1;
            state_d    = (word_idx_q + 16'd1 == len_q) ? S_DONE : S_DATA;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of load frames plus directed abort/boundary sequences.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [31:0] imem_wr_addr;
   logic [31:0] imem_wr_data;
   logic        imem_wr_en;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   program_loader dut (
      .clk(clk), .arst(arst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
      .imem_wr_en(imem_wr_en), .core_hold(core_hold), .busy(busy), .done(done),
      .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Write monitor: strobe is a single cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_wr_en) begin
         wr_addr_q.push_back(imem_wr_addr);
         wr_data_q.push_back(imem_wr_data);
      end
   end

   typedef struct {
      string       name;
      logic [79:0] bytes;
      int          nbytes;
      bit          gaps;
      int          exp_nwr;
      logic [31:0] exp_w0;
      logic [31:0] exp_w1;
      logic        exp_done;
      logic        exp_err;
      logic [15:0] exp_wl;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit ok;
      if (gaps) begin
         int g;
         g = int'($urandom_range(0, 3));
         rx_valid = 1'b0;
         for (int i = 0; i < g; i++) @(negedge clk);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (rx_ready) begin
            @(negedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("rx_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start();
      for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[8*i +: 8], v.gaps);
      settle(4);
      chk({v.name, "_nwr"}, 32'(wr_addr_q.size()), 32'(v.exp_nwr));
      if (wr_addr_q.size() >= 1 && v.exp_nwr >= 1) begin
         chk({v.name, "_a0"}, wr_addr_q[0], 32'h0);
         chk({v.name, "_d0"}, wr_data_q[0], v.exp_w0);
      end
      if (wr_addr_q.size() >= 2 && v.exp_nwr >= 2) begin
         chk({v.name, "_a1"}, wr_addr_q[1], 32'h4);
         chk({v.name, "_d1"}, wr_data_q[1], v.exp_w1);
      end
      chk({v.name, "_done"}, 32'(done), 32'(v.exp_done));
      chk({v.name, "_err"}, 32'(error), 32'(v.exp_err));
      chk({v.name, "_hold"}, 32'(core_hold), 32'(!v.exp_done));
      chk({v.name, "_busy"}, 32'(busy), 32'd0);
      chk({v.name, "_rdy"}, 32'(rx_ready), 32'd0);
      chk({v.name, "_wl"}, 32'(words_loaded), 32'(v.exp_wl));
   endtask

   initial begin
      // bytes are listed LSB-first: byte 0 of the stream is bits [7:0]
      vecs[0] = '{"load2", 80'h00_20_05_93_00_10_05_13_00_02, 10, 1'b0, 2,
                  32'h00100513, 32'h00200593, 1'b1, 1'b0, 16'd2};
      vecs[1] = '{"load2_gaps", 80'h00_20_05_93_00_10_05_13_00_02, 10, 1'b1, 2,
                  32'h00100513, 32'h00200593, 1'b1, 1'b0, 16'd2};
      vecs[2] = '{"len0", 80'h00_00, 2, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 16'd0};
      vecs[3] = '{"len257", 80'h01_01, 2, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0};
      vecs[4] = '{"load1", 80'hde_ad_be_ef_00_01, 6, 1'b1, 1,
                  32'hdeadbeef, 32'h0, 1'b1, 1'b0, 16'd1};

      // Reset state
      settle(2);
      chk("rst_hold", 32'(core_hold), 32'd1);
      chk("rst_rdy", 32'(rx_ready), 32'd0);
      chk("rst_wren", 32'(imem_wr_en), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wl", 32'(words_loaded), 32'd0);
      arst = 1'b0;
      settle(2);
      chk("idle_rdy", 32'(rx_ready), 32'd0);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
         if (i == 0) begin
            chk("hold_addr", imem_wr_addr, 32'h4);
            chk("hold_data", imem_wr_data, 32'h00200593);
         end
         if (i == 3) begin
            pulse_start();
            chk("err_restart_err", 32'(error), 32'd0);
            chk("err_restart_busy", 32'(busy), 32'd1);
            chk("err_restart_rdy", 32'(rx_ready), 32'd1);
            chk("err_restart_hold", 32'(core_hold), 32'd1);
            send_byte(8'h00, 1'b0);
            send_byte(8'h00, 1'b0);
            settle(2);
         end
      end

      // Restart from DONE re-asserts core_hold
      pulse_start();
      chk("done_restart_hold", 32'(core_hold), 32'd1);
      chk("done_restart_done", 32'(done), 32'd0);
      // start mid-load is ignored
      pulse_start();
      chk("start_ignored_rdy", 32'(rx_ready), 32'd1);

      // Abort after two data bytes of word 0
      wr_addr_q.delete();
      wr_data_q.delete();
      arst = 1'b1;
      settle(1);
      arst = 1'b0;
      pulse_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'h05, 1'b0);
      @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hold", 32'(core_hold), 32'd1);
      chk("abort_rdy", 32'(rx_ready), 32'd0);
      arst = 1'b0;
      settle(3);
      chk("abort_nwr", 32'(wr_addr_q.size()), 32'd0);
      run_vec(vecs[0]);

      // Maximum length: 256 words, no error
      begin
         int bad;
         logic [7:0] w8;
         wr_addr_q.delete();
         wr_data_q.delete();
         pulse_start();
         send_byte(8'h00, 1'b0);
         send_byte(8'h01, 1'b0);
         @(negedge clk);
         chk("max_err", 32'(error), 32'd0);
         chk("max_busy", 32'(busy), 32'd1);
         for (int w = 0; w < 256; w++) begin
            w8 = 8'(w);
            send_byte(w8, 1'b0);
            send_byte(~w8, 1'b0);
            send_byte(8'h5a, 1'b0);
            send_byte(w8 ^ 8'h3c, 1'b0);
         end
         settle(4);
         chk("max_nwr", 32'(wr_addr_q.size()), 32'd256);
         bad = 0;
         for (int w = 0; w < wr_addr_q.size(); w++) begin
            w8 = 8'(w);
            if (wr_addr_q[w] !== 32'(w * 4) ||
                wr_data_q[w] !== {w8 ^ 8'h3c, 8'h5a, ~w8, w8}) bad++;
         end
         chk("max_words_bad", 32'(bad), 32'd0);
         chk("max_done", 32'(done), 32'd1);
         chk("max_wl", 32'(words_loaded), 32'd256);
         chk("max_last_addr", imem_wr_addr, 32'h3fc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
